// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/stall/flush and an internal write-back mux.
// Optional retire counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int DATA_W           = 16,
  parameter int REG_AW           = 3,
  parameter int NEG_EDGE         = 1,
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_Valid,
  input  logic              i_Stall,
  input  logic              i_Flush,
  input  logic              i_Sig_MemtoReg,
  input  logic              i_Sig_RegWrite,
  input  logic [REG_AW-1:0] i_Write_Register,
  input  logic [DATA_W-1:0] i_Read_Data,
  input  logic [DATA_W-1:0] i_ALU_Result,
  output logic              o_Valid,
  output logic              o_Sig_MemtoReg,
  output logic              o_Sig_RegWrite,
  output logic [REG_AW-1:0] o_Write_Register,
  output logic [DATA_W-1:0] o_Read_Data,
  output logic [DATA_W-1:0] o_ALU_Result,
  output logic [DATA_W-1:0] o_Write_Data,
  output logic              o_Reg_We
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  input  logic              i_Cnt_Clr,
  output logic [31:0]       o_Retire_Cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              memtoreg;
    logic              regwrite;
    logic [REG_AW-1:0] wr_reg;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] alu;
  } stage_t;

  stage_t stage_d, stage_q;
  logic   load;

  if (DATA_W < 1 || REG_AW < 1) begin : g_bad_width
    $error("mem_wb_stage: DATA_W and REG_AW must both be at least 1");
  end

  assign load = !i_Flush && !i_Stall;

  always_comb begin
    stage_d = stage_q;
    if (i_Flush) begin
      stage_d = '0;
    end else if (!i_Stall) begin
      stage_d.valid    = i_Valid;
      stage_d.memtoreg = i_Sig_MemtoReg;
      stage_d.regwrite = i_Sig_RegWrite;
      stage_d.wr_reg   = i_Write_Register;
      stage_d.rd_data  = i_Read_Data;
      stage_d.alu      = i_ALU_Result;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_d, retire_cnt_q;

  // Clear wins over an increment on the same edge; wraps naturally at 2^32.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (i_Cnt_Clr) begin
      retire_cnt_d = '0;
    end else if (load && i_Valid) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  assign o_Retire_Cnt = retire_cnt_q;
`endif

  // One capture edge per build: the register bank is elaborated for exactly one polarity.
  if (NEG_EDGE != 0) begin : g_neg
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
`ifdef MEM_WB_RETIRE_CNT_EN
        retire_cnt_q <= '0;
`endif
      end else begin
        stage_q <= stage_d;
`ifdef MEM_WB_RETIRE_CNT_EN
        retire_cnt_q <= retire_cnt_d;
`endif
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
`ifdef MEM_WB_RETIRE_CNT_EN
        retire_cnt_q <= '0;
`endif
      end else begin
        stage_q <= stage_d;
`ifdef MEM_WB_RETIRE_CNT_EN
        retire_cnt_q <= retire_cnt_d;
`endif
      end
    end
  end

  assign o_Valid          = stage_q.valid;
  assign o_Sig_MemtoReg   = stage_q.memtoreg;
  assign o_Sig_RegWrite   = stage_q.regwrite;
  assign o_Write_Register = stage_q.wr_reg;
  assign o_Read_Data      = stage_q.rd_data;
  assign o_ALU_Result     = stage_q.alu;

  // Write-back mux and qualified enable; a stalled valid write simply repeats.
  assign o_Write_Data = stage_q.memtoreg ? stage_q.rd_data : stage_q.alu;
  assign o_Reg_We     = stage_q.valid && stage_q.regwrite &&
                        ((ZERO_REG_PROTECT != 0) ? (stage_q.wr_reg != '0) : 1'b1);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a falling-edge/zero-protect instance and a
// rising-edge/no-protect instance share one stimulus stream and one reference model.
module tb_mem_wb_stage;

  logic        clk, rst_n;
  logic        i_Valid, i_Stall, i_Flush, i_Sig_MemtoReg, i_Sig_RegWrite;
  logic [2:0]  i_Write_Register;
  logic [15:0] i_Read_Data, i_ALU_Result;
  logic        i_Cnt_Clr;

  logic        n_Valid, n_M2R, n_RW, n_We;
  logic [2:0]  n_WR;
  logic [15:0] n_RD, n_ALU, n_WD;
  logic        p_Valid, p_M2R, p_RW, p_We;
  logic [2:0]  p_WR;
  logic [15:0] p_RD, p_ALU, p_WD;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] n_Cnt, p_Cnt;
`endif

  mem_wb_stage #(.DATA_W(16), .REG_AW(3), .NEG_EDGE(1), .ZERO_REG_PROTECT(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_Valid(i_Valid), .i_Stall(i_Stall), .i_Flush(i_Flush),
    .i_Sig_MemtoReg(i_Sig_MemtoReg), .i_Sig_RegWrite(i_Sig_RegWrite),
    .i_Write_Register(i_Write_Register), .i_Read_Data(i_Read_Data), .i_ALU_Result(i_ALU_Result),
    .o_Valid(n_Valid), .o_Sig_MemtoReg(n_M2R), .o_Sig_RegWrite(n_RW),
    .o_Write_Register(n_WR), .o_Read_Data(n_RD), .o_ALU_Result(n_ALU),
    .o_Write_Data(n_WD), .o_Reg_We(n_We)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .i_Cnt_Clr(i_Cnt_Clr), .o_Retire_Cnt(n_Cnt)
`endif
  );

  mem_wb_stage #(.DATA_W(16), .REG_AW(3), .NEG_EDGE(0), .ZERO_REG_PROTECT(0)) dut_pe (
    .clk(clk), .rst_n(rst_n), .i_Valid(i_Valid), .i_Stall(i_Stall), .i_Flush(i_Flush),
    .i_Sig_MemtoReg(i_Sig_MemtoReg), .i_Sig_RegWrite(i_Sig_RegWrite),
    .i_Write_Register(i_Write_Register), .i_Read_Data(i_Read_Data), .i_ALU_Result(i_ALU_Result),
    .o_Valid(p_Valid), .o_Sig_MemtoReg(p_M2R), .o_Sig_RegWrite(p_RW),
    .o_Write_Register(p_WR), .o_Read_Data(p_RD), .o_ALU_Result(p_ALU),
    .o_Write_Data(p_WD), .o_Reg_We(p_We)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .i_Cnt_Clr(i_Cnt_Clr), .o_Retire_Cnt(p_Cnt)
`endif
  );

  typedef struct {
    logic        v, m2r, rw;
    logic [2:0]  wr;
    logic [15:0] rd, alu;
    logic [31:0] cnt;
  } st_t;

  typedef struct {
    st_t pv;
    st_t nw;
  } ent_t;

  ent_t q[$];
  st_t  mdl;
  st_t  zero_st;
  int   checks = 0;
  int   errors = 0;
  event rst_ev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] exp_wd(st_t s);
    return s.m2r ? s.rd : s.alu;
  endfunction

  function automatic logic exp_we(st_t s, bit zrp);
    return s.v & s.rw & (zrp ? (s.wr != 3'd0) : 1'b1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(string tag, logic v, logic m2r, logic rw, logic [2:0] wr,
                           logic [15:0] rd, logic [15:0] alu, logic [15:0] wd,
                           logic we, st_t e, bit zrp);
    chk({tag, ".valid"},    {31'd0, v},   {31'd0, e.v});
    chk({tag, ".memtoreg"}, {31'd0, m2r}, {31'd0, e.m2r});
    chk({tag, ".regwrite"}, {31'd0, rw},  {31'd0, e.rw});
    chk({tag, ".wr_reg"},   {29'd0, wr},  {29'd0, e.wr});
    chk({tag, ".rd_data"},  {16'd0, rd},  {16'd0, e.rd});
    chk({tag, ".alu"},      {16'd0, alu}, {16'd0, e.alu});
    chk({tag, ".wr_data"},  {16'd0, wd},  {16'd0, exp_wd(e)});
    chk({tag, ".reg_we"},   {31'd0, we},  {31'd0, exp_we(e, zrp)});
  endtask

  // Rising edge: the rising-edge instance has captured, the falling-edge one must still hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        chk_state("pos_capture", p_Valid, p_M2R, p_RW, p_WR, p_RD, p_ALU, p_WD, p_We, q[0].nw, 1'b0);
        chk_state("neg_hold", n_Valid, n_M2R, n_RW, n_WR, n_RD, n_ALU, n_WD, n_We, q[0].pv, 1'b1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        ent_t e;
        e = q.pop_front();
        chk_state("neg_capture", n_Valid, n_M2R, n_RW, n_WR, n_RD, n_ALU, n_WD, n_We, e.nw, 1'b1);
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("retire_cnt", n_Cnt, e.nw.cnt);
`endif
      end
    end
  end

  initial begin
    forever begin
      @(rst_ev);
      #1;
      chk_state("rst_neg", n_Valid, n_M2R, n_RW, n_WR, n_RD, n_ALU, n_WD, n_We, zero_st, 1'b1);
      chk_state("rst_pos", p_Valid, p_M2R, p_RW, p_WR, p_RD, p_ALU, p_WD, p_We, zero_st, 1'b0);
`ifdef MEM_WB_RETIRE_CNT_EN
      chk("rst_cnt", n_Cnt, 32'd0);
`endif
    end
  end

  // Called at negedge+2: drive one vector, predict the post-edge state, wait one cycle.
  task automatic cycle(logic v, logic st, logic fl, logic m2r, logic rw, logic [2:0] wr,
                       logic [15:0] rd, logic [15:0] alu, logic clr);
    ent_t e;
    i_Valid = v; i_Stall = st; i_Flush = fl; i_Sig_MemtoReg = m2r; i_Sig_RegWrite = rw;
    i_Write_Register = wr; i_Read_Data = rd; i_ALU_Result = alu; i_Cnt_Clr = clr;
    e.pv = mdl;
    e.nw = mdl;
    if (fl) begin
      e.nw.v = 1'b0; e.nw.m2r = 1'b0; e.nw.rw = 1'b0;
      e.nw.wr = 3'd0; e.nw.rd = 16'd0; e.nw.alu = 16'd0;
    end else if (!st) begin
      e.nw.v = v; e.nw.m2r = m2r; e.nw.rw = rw;
      e.nw.wr = wr; e.nw.rd = rd; e.nw.alu = alu;
    end
    if (clr) e.nw.cnt = 32'd0;
    else if (!fl && !st && v) e.nw.cnt = mdl.cnt + 32'd1;
    mdl = e.nw;
    q.push_back(e);
    @(negedge clk);
    #2;
  endtask

  initial begin
    zero_st = '{v: 1'b0, m2r: 1'b0, rw: 1'b0, wr: 3'd0, rd: 16'd0, alu: 16'd0, cnt: 32'd0};
    mdl = zero_st;
    rst_n = 1'b0;
    i_Valid = 1'b0; i_Stall = 1'b0; i_Flush = 1'b0; i_Sig_MemtoReg = 1'b0;
    i_Sig_RegWrite = 1'b0; i_Write_Register = 3'd0; i_Read_Data = 16'd0;
    i_ALU_Result = 16'd0; i_Cnt_Clr = 1'b0;
    #2;
    -> rst_ev;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Propagate, then switch write-back source.
    cycle(1, 0, 0, 1, 1, 3'd5, 16'hBEEF, 16'h1234, 0);
    cycle(1, 0, 0, 0, 1, 3'd5, 16'hBEEF, 16'h1234, 0);
    // Write to r0: suppressed only with protection.
    cycle(1, 0, 0, 0, 1, 3'd0, 16'h1111, 16'h2222, 0);
    // Stall hold then flush-over-stall.
    cycle(1, 0, 0, 0, 1, 3'd3, 16'h0000, 16'h00AA, 0);
    cycle(1, 1, 0, 0, 1, 3'd6, 16'h0055, 16'h0055, 0);
    cycle(1, 1, 0, 1, 0, 3'd6, 16'h0055, 16'h0055, 0);
    cycle(1, 1, 0, 0, 1, 3'd6, 16'h0055, 16'h0055, 0);
    cycle(1, 1, 1, 0, 1, 3'd6, 16'h0055, 16'h0055, 0);
    // Bubble with RegWrite set, then a real write.
    cycle(0, 0, 0, 0, 1, 3'd4, 16'h0F0F, 16'hF0F0, 0);
    cycle(1, 0, 0, 1, 1, 3'd2, 16'hCAFE, 16'h0001, 0);

    // Async reset between edges while a write is enabled.
    rst_n = 1'b0;
    mdl = zero_st;
    -> rst_ev;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Retirement mix: 5 valid, 2 bubbles, 1 stall, 1 flush.
    cycle(1, 0, 0, 0, 1, 3'd1, 16'h0001, 16'h0101, 0);
    cycle(1, 0, 0, 0, 0, 3'd2, 16'h0002, 16'h0202, 0);
    cycle(0, 0, 0, 0, 1, 3'd3, 16'h0003, 16'h0303, 0);
    cycle(1, 0, 0, 1, 1, 3'd4, 16'h0004, 16'h0404, 0);
    cycle(1, 1, 0, 1, 1, 3'd5, 16'h0005, 16'h0505, 0);
    cycle(0, 0, 0, 0, 1, 3'd6, 16'h0006, 16'h0606, 0);
    cycle(1, 0, 1, 0, 1, 3'd7, 16'h0007, 16'h0707, 0);
    cycle(1, 0, 0, 0, 1, 3'd7, 16'h0008, 16'h0808, 0);
    cycle(1, 0, 0, 1, 1, 3'd1, 16'h0009, 16'h0909, 0);
    // Clear overrides a simultaneous retirement.
    cycle(1, 0, 0, 0, 1, 3'd2, 16'h000A, 16'h0A0A, 1);

`ifdef MEM_WB_RETIRE_CNT_EN
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    mdl.cnt = 32'hFFFF_FFFF;
`endif
    cycle(1, 0, 0, 0, 1, 3'd3, 16'h000B, 16'h0B0B, 0);
    cycle(0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 0);

    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register for the pipelined MIPS core. It is the successor to the fixed 16-bit/3-bit MEM/WB latch. It adds:
- configurable data and register-address widths and a selectable capture edge;
- a valid bit, with stall (hold) and flush (bubble) control;
- an internal write-back mux, so the register file receives one write-data bus and one qualified write-enable.

Parameters:
DATA_W, 16, width of memory read data, ALU result and write-back data
REG_AW, 3, register-file address width
NEG_EDGE, 1, 1 = capture on falling edge of clk; 0 = rising edge
ZERO_REG_PROTECT, 1, 1 = suppress write-enable when write address is 0

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
i_Valid  input  1  MEM stage holds a real instruction
i_Stall  input  1  hold current contents (WB stalled)
i_Flush  input  1  load a bubble
i_Sig_MemtoReg  input  1  1 = write back memory data, 0 = ALU result
i_Sig_RegWrite  input  1  instruction writes register file
i_Write_Register  input  REG_AW  destination register
i_Read_Data  input  DATA_W  data-memory read data
i_ALU_Result  input  DATA_W  ALU result
o_Valid  output  1  WB stage holds a real instruction
o_Sig_MemtoReg  output  1  registered MemtoReg
o_Sig_RegWrite  output  1  registered raw RegWrite
o_Write_Register  output  REG_AW  registered destination
o_Read_Data  output  DATA_W  registered read data
o_ALU_Result  output  DATA_W  registered ALU result
o_Write_Data  output  DATA_W  write-back data to register file
o_Reg_We  output  1  qualified register-file write enable

Behaviour:
- All state updates occur on the active edge only: negedge clk if NEG_EDGE=1, posedge clk if NEG_EDGE=0. Selection is by generate; there is one edge per build.
- Reset:
  - rst_n low clears asynchronously, independent of clk.
  - All registered outputs go to 0: o_Valid, o_Sig_MemtoReg, o_Sig_RegWrite, o_Write_Register, o_Read_Data, o_ALU_Result.
  - Hence o_Write_Data=0 and o_Reg_We=0 during reset.
  - Reset asserted mid-operation discards the in-flight instruction; no partial write occurs.
- Each active edge applies the first matching rule, in this priority:
  1. i_Flush=1: o_Valid<=0 and o_Sig_RegWrite<=0. Data and address fields are don't-care; the implementation loads 0. Flush beats stall.
  2. i_Stall=1: all registers hold their values.
  3. Otherwise: every o_* register loads its i_* counterpart, and o_Valid<=i_Valid.
- Latency: one active edge from input to registered output.
- o_Write_Data is combinational from registered state: o_Sig_MemtoReg ? o_Read_Data : o_ALU_Result.
- o_Reg_We is combinational: o_Valid & o_Sig_RegWrite & (ZERO_REG_PROTECT ? (o_Write_Register != 0) : 1).
- Bubbles:
  - i_Valid=0 with no stall/flush captures a bubble. Fields load normally but o_Reg_We=0 because o_Valid=0.
  - Back-to-back instructions need no idle cycles.
- Stall: during a stall, o_Reg_We stays asserted if it was asserted. The register file must tolerate repeated identical writes; this is idempotent.
- Widths:
  - No arithmetic is performed; no truncation or extension.
  - REG_AW≥1 and DATA_W≥1 are required; elaboration fails otherwise via generate error.

Optional Feature:
Macro MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output o_Retire_Cnt, width 32, and input i_Cnt_Clr, width 1.
  - The counter uses the same active edge and async reset to 0.
  - Each active edge where the stage loads (no stall, no flush) with i_Valid=1, the counter increments by 1.
  - The counter wraps from 0xFFFFFFFF to 0.
  - i_Cnt_Clr=1 sets it to 0 and overrides an increment on the same edge.
  - It counts instructions entering WB, including those with RegWrite=0.
- Undefined: the ports and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then propagate (NEG_EDGE=1):
   - Stimulus: hold rst_n=0 and check every output is 0. Release rst_n, then drive i_Valid=1, RegWrite=1, MemtoReg=1, Write_Register=5, Read_Data=0xBEEF, ALU_Result=0x1234.
   - Required response: outputs update only after the falling edge; o_Write_Data=0xBEEF and o_Reg_We=1. With MemtoReg=0 next cycle, o_Write_Data=0x1234.
2. Zero-register protect:
   - Stimulus: Write_Register=0, RegWrite=1, Valid=1.
   - Required response: o_Reg_We=0 when ZERO_REG_PROTECT=1; o_Reg_We=1 when ZERO_REG_PROTECT=0.
3. Stall hold and flush priority:
   - Stimulus: load ALU_Result=0x00AA, then assert i_Stall for 3 edges while inputs change to 0x0055. Next, assert i_Stall=1 and i_Flush=1 together.
   - Required response: outputs hold 0x00AA through the stall. On the combined stall+flush edge, o_Valid=0 and o_Reg_We=0.
4. Async reset mid-stream:
   - Stimulus: assert rst_n=0 between clock edges while o_Reg_We=1.
   - Required response: o_Reg_We and all registered outputs drop to 0 immediately, without waiting for an edge.
5. Bubble and edge select:
   - Stimulus: i_Valid=0 with RegWrite=1 gives o_Reg_We=0. Rerun scenario 1 with NEG_EDGE=0.
   - Required response: with NEG_EDGE=0, capture occurs on the rising edge only.
6. Retire counter (MEM_WB_RETIRE_CNT_EN):
   - Stimulus: send 5 valid instructions, 2 bubbles, 1 stalled edge and 1 flushed edge.
   - Required response: o_Retire_Cnt=5. Assert i_Cnt_Clr while a valid instruction loads and the counter reads 0. Preload 0xFFFFFFFF, retire 1 instruction, and the counter reads 0.
